// File: rtl/mips_pkg.sv
// Shared encodings for the multiply/divide unit: op codes, funct values and FSM states.
package mips_pkg;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIV   = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;
    localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
    localparam logic [5:0] FUNCT_MTLO  = 6'b010011;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_CALC = 2'b01,
        MD_FIX  = 2'b10
    } md_state_t;

    // Decoder helpers: map an R-type funct onto the unit's controls.
    function automatic logic funct_is_md(input logic [5:0] funct);
        return (funct == FUNCT_MULT) || (funct == FUNCT_MULTU) ||
               (funct == FUNCT_DIV)  || (funct == FUNCT_DIVU);
    endfunction

    function automatic logic [1:0] md_op_from_funct(input logic [5:0] funct);
        logic [1:0] op;
        case (funct)
            FUNCT_MULTU: op = MD_MULTU;
            FUNCT_DIV:   op = MD_DIV;
            FUNCT_DIVU:  op = MD_DIVU;
            default:     op = MD_MULT;
        endcase
        return op;
    endfunction

    function automatic logic funct_is_mthi(input logic [5:0] funct);
        return funct == FUNCT_MTHI;
    endfunction

    function automatic logic funct_is_mtlo(input logic [5:0] funct);
        return funct == FUNCT_MTLO;
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers: one shift-add or
// restoring-divide step per cycle on operand magnitudes, sign fixup at the end.
module muldiv_unit
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             hi_we,
    input  logic             lo_we,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
        return ~x + WIDTH'(1);
    endfunction

    function automatic logic [WIDTH-1:0] abs_w(input logic [WIDTH-1:0] x, input logic sgn);
        return (sgn && x[WIDTH-1]) ? neg_w(x) : x;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
        return ~x + (2*WIDTH)'(1);
    endfunction

    md_state_t          state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [WIDTH-1:0]   acc_q, acc_d;     // product high half / partial remainder
    logic [WIDTH-1:0]   quo_q, quo_d;     // multiplier / dividend, shifted into result
    logic [WIDTH-1:0]   opnd_q, opnd_d;   // multiplicand / divisor magnitude
    logic               is_div_q, is_div_d;
    logic               res_neg_q, res_neg_d;
    logic               rem_neg_q, rem_neg_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               op_signed;
    logic               op_div;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     shifted;
    logic [WIDTH-1:0]   diff;
    logic [2*WIDTH-1:0] prod;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= MD_IDLE;
            count_q   <= '0;
            acc_q     <= '0;
            quo_q     <= '0;
            opnd_q    <= '0;
            is_div_q  <= 1'b0;
            res_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            acc_q     <= acc_d;
            quo_q     <= quo_d;
            opnd_q    <= opnd_d;
            is_div_q  <= is_div_d;
            res_neg_q <= res_neg_d;
            rem_neg_q <= rem_neg_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        acc_d     = acc_q;
        quo_d     = quo_q;
        opnd_d    = opnd_q;
        is_div_d  = is_div_q;
        res_neg_d = res_neg_q;
        rem_neg_d = rem_neg_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        sum       = '0;
        shifted   = '0;
        diff      = '0;
        prod      = '0;
        op_signed = (op == MD_MULT) || (op == MD_DIV);
        op_div    = (op == MD_DIV) || (op == MD_DIVU);

        case (state_q)
            MD_IDLE: begin
                if (start) begin
                    acc_d     = '0;
                    quo_d     = op_div ? abs_w(rs_data, op_signed) : abs_w(rt_data, op_signed);
                    opnd_d    = op_div ? abs_w(rt_data, op_signed) : abs_w(rs_data, op_signed);
                    is_div_d  = op_div;
                    // A zero divisor keeps the all-ones quotient; the remainder fixup
                    // then restores the original dividend into HI.
                    res_neg_d = op_signed && (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]) &&
                                !(op_div && (rt_data == '0));
                    rem_neg_d = op_signed && op_div && rs_data[WIDTH-1];
                    count_d   = CNT_W'(WIDTH-1);
                    state_d   = MD_CALC;
                end else begin
                    if (hi_we) hi_d = rs_data;
                    if (lo_we) lo_d = rs_data;
                end
            end
            MD_CALC: begin
                if (is_div_q) begin
                    shifted = {acc_q, quo_q[WIDTH-1]};
                    diff    = shifted[WIDTH-1:0] - opnd_q;
                    if (shifted >= {1'b0, opnd_q}) begin
                        acc_d = diff;
                        quo_d = {quo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = shifted[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    sum   = {1'b0, acc_q} + (quo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
                    acc_d = sum[WIDTH:1];
                    quo_d = {sum[0], quo_q[WIDTH-1:1]};
                end
                if (count_q == '0) begin
                    state_d = MD_FIX;
                end else begin
                    count_d = count_q - CNT_W'(1);
                end
            end
            MD_FIX: begin
                if (is_div_q) begin
                    lo_d = res_neg_q ? neg_w(quo_q) : quo_q;
                    hi_d = rem_neg_q ? neg_w(acc_q) : acc_q;
                end else begin
                    prod = res_neg_q ? neg_2w({acc_q, quo_q}) : {acc_q, quo_q};
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end
                done_d  = 1'b1;
                state_d = MD_IDLE;
            end
            default: state_d = MD_IDLE;
        endcase

        busy_d = (state_d != MD_IDLE);
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit.
module tb_muldiv_unit;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    int pass_cnt  = 0;
    int total_cnt = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .rs_data(rs_data), .rt_data(rt_data),
        .hi_we(hi_we), .lo_we(lo_we),
        .hi(hi), .lo(lo), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        op = o; rs_data = a; rt_data = b; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Advance until done (bounded); cyc = edges since the start edge.
    task automatic wait_done(output bit ok, output int cyc, output int busy_cyc);
        cyc = 0;
        busy_cyc = 0;
        while (!done && cyc < 60) begin
            if (busy) busy_cyc++;
            tick();
            cyc++;
        end
        ok = (done === 1'b1);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; op = 2'b00; rs_data = '0; rt_data = '0;
        hi_we = 1'b0; lo_we = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else pass_cnt++;
        total_cnt++; if (hi !== 32'h0) $display("FAIL reset_hi: got %h want 0", hi); else pass_cnt++;
        total_cnt++; if (lo !== 32'h0) $display("FAIL reset_lo: got %h want 0", lo); else pass_cnt++;
    endtask

    task automatic test_mult();
        bit ok; int cyc; int bc;
        launch(MD_MULT, 32'd7, 32'hFFFFFFFD);
        wait_done(ok, cyc, bc);
        total_cnt++; if (!ok) $display("FAIL mult_timeout: done never seen"); else pass_cnt++;
        total_cnt++; if (cyc != 33) $display("FAIL mult_latency: got %0d want 33", cyc); else pass_cnt++;
        total_cnt++; if (hi !== 32'hFFFFFFFF) $display("FAIL mult_hi: got %h want ffffffff", hi); else pass_cnt++;
        total_cnt++; if (lo !== 32'hFFFFFFEB) $display("FAIL mult_lo: got %h want ffffffeb", lo); else pass_cnt++;
        tick();
        total_cnt++; if (done !== 1'b0) $display("FAIL mult_done_pulse: got %b want 0", done); else pass_cnt++;
    endtask

    task automatic test_multu();
        bit ok; int cyc; int bc;
        launch(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(ok, cyc, bc);
        total_cnt++; if (bc != 33) $display("FAIL multu_busy_cycles: got %0d want 33", bc); else pass_cnt++;
        total_cnt++; if (hi !== 32'hFFFFFFFE) $display("FAIL multu_hi: got %h want fffffffe", hi); else pass_cnt++;
        total_cnt++; if (lo !== 32'h00000001) $display("FAIL multu_lo: got %h want 00000001", lo); else pass_cnt++;
        tick();
    endtask

    task automatic test_div();
        bit ok; int cyc; int bc;
        launch(MD_DIV, 32'hFFFFFFF9, 32'd2);
        wait_done(ok, cyc, bc);
        total_cnt++; if (lo !== 32'hFFFFFFFD) $display("FAIL div_neg_lo: got %h want fffffffd", lo); else pass_cnt++;
        total_cnt++; if (hi !== 32'hFFFFFFFF) $display("FAIL div_neg_hi: got %h want ffffffff", hi); else pass_cnt++;
        tick();
        launch(MD_DIVU, 32'd7, 32'd2);
        wait_done(ok, cyc, bc);
        total_cnt++; if (lo !== 32'd3) $display("FAIL divu_lo: got %h want 3", lo); else pass_cnt++;
        total_cnt++; if (hi !== 32'd1) $display("FAIL divu_hi: got %h want 1", hi); else pass_cnt++;
        tick();
    endtask

    task automatic test_div_corner();
        bit ok; int cyc; int bc;
        launch(MD_DIV, 32'd5, 32'd0);
        wait_done(ok, cyc, bc);
        total_cnt++; if (lo !== 32'hFFFFFFFF) $display("FAIL div0_lo: got %h want ffffffff", lo); else pass_cnt++;
        total_cnt++; if (hi !== 32'd5) $display("FAIL div0_hi: got %h want 5", hi); else pass_cnt++;
        tick();
        launch(MD_DIV, 32'hFFFFFFFB, 32'd0);
        wait_done(ok, cyc, bc);
        total_cnt++; if (lo !== 32'hFFFFFFFF) $display("FAIL div0_neg_lo: got %h want ffffffff", lo); else pass_cnt++;
        total_cnt++; if (hi !== 32'hFFFFFFFB) $display("FAIL div0_neg_hi: got %h want fffffffb", hi); else pass_cnt++;
        tick();
        launch(MD_DIV, 32'h80000000, 32'hFFFFFFFF);
        wait_done(ok, cyc, bc);
        total_cnt++; if (lo !== 32'h80000000) $display("FAIL div_ovf_lo: got %h want 80000000", lo); else pass_cnt++;
        total_cnt++; if (hi !== 32'h0) $display("FAIL div_ovf_hi: got %h want 0", hi); else pass_cnt++;
        tick();
    endtask

    task automatic test_mt();
        rs_data = 32'h00005A5A; hi_we = 1'b1;
        tick();
        hi_we = 1'b0;
        total_cnt++; if (hi !== 32'h00005A5A) $display("FAIL mthi: got %h want 00005a5a", hi); else pass_cnt++;
        rs_data = 32'h77; hi_we = 1'b1; lo_we = 1'b1;
        tick();
        hi_we = 1'b0; lo_we = 1'b0;
        total_cnt++; if (hi !== 32'h77) $display("FAIL mt_both_hi: got %h want 77", hi); else pass_cnt++;
        total_cnt++; if (lo !== 32'h77) $display("FAIL mt_both_lo: got %h want 77", lo); else pass_cnt++;
        rs_data = 32'h1234; lo_we = 1'b1;
        tick();
        lo_we = 1'b0;
        total_cnt++; if (lo !== 32'h1234) $display("FAIL mtlo: got %h want 1234", lo); else pass_cnt++;
    endtask

    task automatic test_start_wins_and_busy_ignore();
        bit ok; int cyc; int bc;
        lo_we = 1'b1; hi_we = 1'b1;
        launch(MD_MULTU, 32'd3, 32'd4);
        lo_we = 1'b0; hi_we = 1'b0;
        total_cnt++; if (lo !== 32'h1234) $display("FAIL start_mtlo_lo: got %h want 1234", lo); else pass_cnt++;
        total_cnt++; if (hi !== 32'h77) $display("FAIL start_mthi_hi: got %h want 77", hi); else pass_cnt++;
        op = MD_DIV; rs_data = 32'd99; rt_data = 32'd11;
        start = 1'b1; hi_we = 1'b1; lo_we = 1'b1;
        repeat (5) tick();
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        total_cnt++; if (hi !== 32'h77) $display("FAIL busy_hold_hi: got %h want 77", hi); else pass_cnt++;
        wait_done(ok, cyc, bc);
        total_cnt++; if (hi !== 32'h0) $display("FAIL busy_ignore_hi: got %h want 0", hi); else pass_cnt++;
        total_cnt++; if (lo !== 32'd12) $display("FAIL busy_ignore_lo: got %h want c", lo); else pass_cnt++;
        tick();
    endtask

    task automatic test_back_to_back();
        bit ok; int cyc; int bc;
        launch(MD_MULTU, 32'd6, 32'd7);
        wait_done(ok, cyc, bc);
        total_cnt++; if (lo !== 32'd42) $display("FAIL b2b_first_lo: got %h want 2a", lo); else pass_cnt++;
        launch(MD_DIVU, 32'd100, 32'd7);
        total_cnt++; if (busy !== 1'b1) $display("FAIL b2b_busy: got %b want 1", busy); else pass_cnt++;
        wait_done(ok, cyc, bc);
        total_cnt++; if (cyc != 33) $display("FAIL b2b_latency: got %0d want 33", cyc); else pass_cnt++;
        total_cnt++; if (lo !== 32'd14) $display("FAIL b2b_lo: got %h want e", lo); else pass_cnt++;
        total_cnt++; if (hi !== 32'd2) $display("FAIL b2b_hi: got %h want 2", hi); else pass_cnt++;
        tick();
    endtask

    task automatic test_reset_mid_op();
        int dones;
        launch(MD_DIV, 32'd100, 32'd7);
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total_cnt++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (done !== 1'b0) $display("FAIL rstmid_done: got %b want 0", done); else pass_cnt++;
        total_cnt++; if (hi !== 32'h0) $display("FAIL rstmid_hi: got %h want 0", hi); else pass_cnt++;
        total_cnt++; if (lo !== 32'h0) $display("FAIL rstmid_lo: got %h want 0", lo); else pass_cnt++;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) dones++;
            tick();
        end
        total_cnt++; if (dones != 0) $display("FAIL rstmid_no_done: got %0d pulses want 0", dones); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_div_corner();
        test_mt();
        test_start_wins_and_busy_ignore();
        test_back_to_back();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
